alu_ctrl_seq: RTL
=================

// Module: alu_ctrl_seq
// PURPOSE
//  Parametrised, registered successor to the combinational ALU control decoder.
//  - Decodes {alu_op, func} into an ALU control code behind valid/ready handshakes.
//  - Sequences the multi-cycle MUL operation with an internal step counter.
//  - Sits between the main control unit and the ALU/multiplier datapath.
// PARAMETERS
//  OP_W        3  alu_op width, >=3; decode uses bits [2:0], any upper bit set = illegal
//  FUNC_W      3  func width, >=3; decode uses bits [2:0], upper bits ignored
//  CTRL_W      3  alu_ctrl width, >=3; code zero-extended
//  MULT_CYCLES 8  cycles spent in MUL state, >=1
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  in_valid   in   1            request present
//  in_ready   out  1            request accepted when in_valid&&in_ready
//  alu_op     in   OP_W         main-control op class
//  func       in   FUNC_W       R-type function field
//  out_valid  out  1            alu_ctrl valid
//  out_ready  in   1            consumer takes alu_ctrl when out_valid&&out_ready
//  alu_ctrl   out  CTRL_W       ALU control code
//  busy       out  1            1 while in MUL state
//  mul_step   out  $clog2(MULT_CYCLES+1)  remaining MUL cycles, 0 outside MUL
//  illegal    out  1            sticky illegal-request flag (ILLEGAL_TRAP_EN only)
// BEHAVIOUR
//  Codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 MUL=7.
//  alu_op 000: func[2:0] 0..7 -> ADD,SUB,AND,OR,XOR,SLT,SLL,MUL.
//  alu_op 001->ADD 010->SUB 011->AND 100->OR 101->SLT 110->XOR; 111 = illegal.
//  Reset (async, immediate, also mid-op): state IDLE, in_ready=1, out_valid=0,
//   alu_ctrl=0, busy=0, mul_step=0, illegal=0.
//  FSM IDLE: in_ready=1. On accept:
//   - non-MUL: go OUT next edge.
//   - MUL: go MUL, mul_step=MULT_CYCLES.
//   - Either way alu_ctrl is registered on the accept edge.
//  FSM MUL: in_ready=0, out_valid=0, busy=1, alu_ctrl=MUL.
//   - mul_step decrements each cycle; on the edge where mul_step==1, go OUT.
//  FSM OUT: out_valid=1; alu_ctrl held stable while !out_ready; in_ready=out_ready.
//   - out_ready && in_valid: accept back-to-back, next state/decode as from IDLE.
//   - out_ready && !in_valid: go IDLE.
//  Latency accept->out_valid: non-MUL 1 cycle; MUL MULT_CYCLES+1 cycles.
//  Throughput: 1 per cycle for non-MUL with out_ready held high.
//  in_valid while in_ready=0: ignored; requester must hold inputs.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//   - illegal request (alu_op[2:0]==111 or any alu_op upper bit set) is accepted
//     but produces no output; FSM stays/returns IDLE.
//   - illegal sets to 1 on the accept edge and stays 1 until reset.
//  ILLEGAL_TRAP_EN undefined:
//   - illegal request decodes as ADD and completes normally.
//   - illegal tied 0.
// TESTING
//  1 Reset: rst_n=0 mid-MUL (mul_step=5) -> out_valid=0, busy=0, mul_step=0, in_ready=1 immediately.
//  2 R-type sweep: alu_op=000, func 0..6 streamed, out_ready=1
//    -> alu_ctrl 0..6 on consecutive cycles, each 1 cycle after accept.
//  3 MUL: alu_op=000 func=111, MULT_CYCLES=8
//    -> busy for 8 cycles, mul_step 8..1, out_valid at accept+9 with alu_ctrl=7.
//  4 Backpressure: alu_op=010, out_ready=0 for 4 cycles
//    -> out_valid=1 with alu_ctrl=1 stable, in_ready=0; out_ready=1 releases.
//  5 Illegal alu_op=111, ILLEGAL_TRAP_EN on -> no out_valid, illegal=1 sticky;
//    ILLEGAL_TRAP_EN off -> alu_ctrl=0, out_valid after 1 cycle.
//  6 MULT_CYCLES=1 edge: MUL -> busy exactly 1 cycle, out_valid at accept+2.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshakes and a MUL step sequencer.
// Optional ILLEGAL_TRAP_EN: swallow illegal alu_op requests and raise a sticky illegal flag.
module alu_ctrl_seq #(
  parameter int OP_W        = 3,
  parameter int FUNC_W      = 3,
  parameter int CTRL_W      = 3,
  parameter int MULT_CYCLES = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [OP_W-1:0]                  alu_op,
  input  logic [FUNC_W-1:0]                func,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CTRL_W-1:0]                alu_ctrl,
  output logic                             busy,
  output logic [$clog2(MULT_CYCLES+1)-1:0] mul_step,
  output logic                             illegal,
  output logic [1:0]                       state_dbg
);

  localparam int SW = $clog2(MULT_CYCLES + 1);

  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_AND = 3'd2, C_OR  = 3'd3,
                         C_XOR = 3'd4, C_SLT = 3'd5, C_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [SW-1:0]     step_q, step_d;
  logic [2:0]        op3, fn3, code;
  logic              op_hi, accept, trap;

  // Handshake: a transfer happens on any rising edge where valid && ready are both
  // high; the producer holds its payload stable while valid is high and ready is low.
  assign op3    = alu_op[2:0];
  assign fn3    = func[2:0];
  assign op_hi  = |(alu_op >> 3);
  assign accept = in_valid && in_ready;

  always_comb begin
    code = C_ADD;
    case (op3)
      3'b000:  code = fn3;
      3'b001:  code = C_ADD;
      3'b010:  code = C_SUB;
      3'b011:  code = C_AND;
      3'b100:  code = C_OR;
      3'b101:  code = C_SLT;
      3'b110:  code = C_XOR;
      default: code = C_ADD;
    endcase
    if (op_hi) code = C_ADD;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap    = op_hi || (op3 == 3'b111);
  assign illegal = illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              illegal_q <= 1'b0;
    else if (accept && trap) illegal_q <= 1'b1;
  end
`else
  assign trap    = 1'b0;
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    step_d  = step_q;
    case (state_q)
      S_MUL: begin
        step_d = step_q - SW'(1);
        if (step_q == SW'(1)) state_d = S_OUT;
      end
      default: begin
        // IDLE and a drained OUT share the accept path, giving back-to-back throughput.
        if (state_q == S_OUT && out_ready) state_d = S_IDLE;
        if (accept) begin
          if (trap) begin
            state_d = S_IDLE;
          end else begin
            ctrl_d = CTRL_W'(code);
            if (code == C_MUL) begin
              state_d = S_MUL;
              step_d  = SW'(MULT_CYCLES);
            end else begin
              state_d = S_OUT;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      step_q  <= step_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_OUT && out_ready);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q == S_MUL);
  assign alu_ctrl  = ctrl_q;
  assign mul_step  = step_q;
  assign state_dbg = state_q;

endmodule
